pwm_cfg_master: RTL

PWM_CFG_MASTER -- requirements
Module: pwm_cfg_master

---
 rtl/pwm_cfg_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pwm_cfg_master.sv
// Command-driven bus master that programs one PWM channel (T, D, E registers)
// or reads the shared status word, with registered bus strobes.
module pwm_cfg_master #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [2:0]  cmd_ch,
  input  logic [31:0] cmd_period,
  input  logic [31:0] cmd_duty,
  input  logic        cmd_en,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        cs,
  output logic        wr,
  output logic        rd,
  output logic [7:0]  addr,
  output logic [31:0] d_out,
  input  logic [31:0] d_in
);

  typedef enum logic [2:0] {IDLE, WR_T, WR_D, WR_E, GAP, RD1, RD2, RSP} state_t;

  state_t      state, state_n, resume, resume_n;
  logic [2:0]  gap_cnt, gap_cnt_n;
  logic [2:0]  ch_q;
  logic [31:0] period_q, duty_q;
  logic        en_q;

  logic        accept;
  logic [2:0]  ch_s;
  logic [31:0] period_s, duty_s;
  logic        en_s, clamp_s;
  logic [7:0]  base_s;

  logic        cs_n, wr_n, rd_n, rsp_valid_n, rsp_err_n, cmd_ready_n;
  logic [7:0]  addr_n;
  logic [31:0] d_out_n, rsp_data_n;

  assign accept = cmd_valid && cmd_ready;

  // Outputs are registered from the next state, so the acceptance cycle must
  // see the raw command fields before they land in the holding registers.
  always_comb begin
    ch_s     = accept ? cmd_ch     : ch_q;
    period_s = accept ? cmd_period : period_q;
    duty_s   = accept ? cmd_duty   : duty_q;
    en_s     = accept ? cmd_en     : en_q;
    clamp_s  = duty_s > period_s;
    base_s   = {5'b0, ch_s} * 8'd12;
  end

  always_comb begin
    state_n   = state;
    resume_n  = resume;
    gap_cnt_n = gap_cnt;
    case (state)
      IDLE: if (accept) state_n = cmd_op ? RD1 : WR_T;
      WR_T: begin
        if (GAP_CYCLES == 0) state_n = WR_D;
        else begin
          state_n   = GAP;
          resume_n  = WR_D;
          gap_cnt_n = 3'(GAP_CYCLES - 1);
        end
      end
      WR_D: begin
        if (GAP_CYCLES == 0) state_n = WR_E;
        else begin
          state_n   = GAP;
          resume_n  = WR_E;
          gap_cnt_n = 3'(GAP_CYCLES - 1);
        end
      end
      WR_E: state_n = RSP;
      GAP: begin
        if (gap_cnt == 3'd0) state_n = resume;
        else gap_cnt_n = gap_cnt - 3'd1;
      end
      RD1:     state_n = RD2;
      RD2:     state_n = RSP;
      RSP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cs_n    = 1'b0;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    addr_n  = '0;
    d_out_n = '0;
    case (state_n)
      WR_T: begin
        cs_n = 1'b1; wr_n = 1'b1;
        addr_n  = base_s + 8'd4;
        d_out_n = period_s;
      end
      WR_D: begin
        cs_n = 1'b1; wr_n = 1'b1;
        addr_n  = base_s + 8'd8;
        d_out_n = clamp_s ? period_s : duty_s;
      end
      WR_E: begin
        cs_n = 1'b1; wr_n = 1'b1;
        addr_n  = base_s;
        d_out_n = {31'b0, en_s};
      end
      RD1, RD2: begin
        cs_n = 1'b1; rd_n = 1'b1;
        addr_n = 8'h60;
      end
      default: ;
    endcase
    rsp_valid_n = (state_n == RSP);
    rsp_err_n   = (state == WR_E) && clamp_s;
    rsp_data_n  = (state == RD2) ? d_in : '0;
    cmd_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      resume    <= IDLE;
      gap_cnt   <= '0;
      ch_q      <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      en_q      <= 1'b0;
      cs        <= 1'b0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      addr      <= '0;
      d_out     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_n;
      resume    <= resume_n;
      gap_cnt   <= gap_cnt_n;
      if (accept) begin
        ch_q     <= cmd_ch;
        period_q <= cmd_period;
        duty_q   <= cmd_duty;
        en_q     <= cmd_en;
      end
      cs        <= cs_n;
      wr        <= wr_n;
      rd        <= rd_n;
      addr      <= addr_n;
      d_out     <= d_out_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_data  <= rsp_data_n;
      cmd_ready <= cmd_ready_n;
    end
  end

endmodule
